// File: rtl/pc_fetch_pkg.sv
// ----------------------------------------------------------------------------
// pc_fetch_pkg
// Shared types and constants for the Hack CPU fetch stage.
//   fetch_state_t : fetch FSM state (S_REQ -> S_RESP -> S_HOLD -> S_RESP ...)
//   HACK_ADDR_W   : Hack ROM address width (32K words)
//   HACK_WORD_W   : Hack instruction word width
// ----------------------------------------------------------------------------
package pc_fetch_pkg;

   localparam int HACK_ADDR_W = 15;
   localparam int HACK_WORD_W = 16;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,   // ROM is sampling fpc on the coming edge
      S_RESP = 2'd1,   // rom_data is valid for fpc; capture it
      S_HOLD = 2'd2    // instruction presented, waiting for decode
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_inc.sv
// ----------------------------------------------------------------------------
// inc
// 16-bit incrementer (Hack Inc16): out_word = in_word + 1, wrapping at 2^16.
// Ports:
//   in_word  in  16  operand
//   out_word out 16  operand + 1
// ----------------------------------------------------------------------------
module inc (
   input  logic [15:0] in_word,
   output logic [15:0] out_word
);

   assign out_word = in_word + 16'd1;

endmodule

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
// Hack CPU program counter and instruction fetch stage. Drives a synchronous
// ROM (1-cycle read latency) from the fetch PC and hands each instruction and
// its address to decode over a valid/ready handshake. A jump from execute
// retargets the fetch PC and drops any in-flight ROM read.
//
// Optional build macro: PC_FETCH_STATS_EN adds a 32-bit fetch_count output
// counting completed handshakes (not cleared by jumps).
//
// Ports:
//   clk          in   1       clock, rising edge
//   reset        in   1       synchronous active-high reset
//   jump_en      in   1       redirect request
//   jump_addr    in   ADDR_W  redirect target
//   rom_addr     out  ADDR_W  ROM read address (= fetch PC register)
//   rom_data     in   DATA_W  ROM data for the address sampled last edge
//   instr_valid  out  1       instruction output valid
//   instr        out  DATA_W  registered instruction
//   instr_pc     out  ADDR_W  address of instr
//   instr_ready  in   1       decode accepts instr
//   fetch_count  out  32      completed handshakes (PC_FETCH_STATS_EN only)
// ----------------------------------------------------------------------------
module pc_fetch_unit
   import pc_fetch_pkg::*;
#(
   parameter int ADDR_W       = HACK_ADDR_W,
   parameter int DATA_W       = HACK_WORD_W,
   parameter int RESET_VECTOR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready
`ifdef PC_FETCH_STATS_EN
   ,
   output logic [31:0]       fetch_count
`endif
);

   localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR);

   fetch_state_t      state_reg, state_next;
   logic [ADDR_W-1:0] fpc_reg, fpc_next;
   logic              valid_reg, valid_next;
   logic [DATA_W-1:0] instr_reg, instr_next;
   logic [ADDR_W-1:0] instr_pc_reg, instr_pc_next;
   logic              handshake;

   // ------------------------------------------------------------------------
   // Next PC through the shared 16-bit incrementer. The PC is zero-extended
   // into the 16-bit operand and the low ADDR_W bits of the result are kept,
   // which gives the modulo-2^ADDR_W wrap for free.
   // ------------------------------------------------------------------------
   logic [15:0] inc_in;
   logic [15:0] inc_out;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_inc_in
         if (gi < ADDR_W) begin : g_pc_bit
            assign inc_in[gi] = fpc_reg[gi];
         end else begin : g_zero_bit
            assign inc_in[gi] = 1'b0;
         end
      end
   endgenerate

   inc u_inc (
      .in_word  (inc_in),
      .out_word (inc_out)
   );

   // valid is only ever set in S_HOLD, so this is the S_HOLD exit condition
   assign handshake = valid_reg && instr_ready;

   // ------------------------------------------------------------------------
   // Next-state / next-data logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      fpc_next      = fpc_reg;
      valid_next    = valid_reg;
      instr_next    = instr_reg;
      instr_pc_next = instr_pc_reg;

      case (state_reg)
         S_REQ: begin
            state_next = S_RESP;
         end
         S_RESP: begin
            instr_next    = rom_data;
            instr_pc_next = fpc_reg;
            valid_next    = 1'b1;
            fpc_next      = inc_out[ADDR_W-1:0];
            state_next    = S_HOLD;
         end
         S_HOLD: begin
            // fpc already points at the next word, so the ROM sampling it on
            // this edge is the request for the following instruction.
            if (handshake) begin
               valid_next = 1'b0;
               state_next = S_RESP;
            end
         end
         default: begin
            state_next = S_REQ;
            valid_next = 1'b0;
         end
      endcase

      // A jump overrides whatever the FSM decided. A handshake on the same
      // edge still counts (decode saw it), but the capture in S_RESP is
      // dropped because valid is forced low and the state returns to S_REQ.
      if (jump_en) begin
         fpc_next   = jump_addr;
         valid_next = 1'b0;
         state_next = S_REQ;
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= S_REQ;
         fpc_reg      <= RESET_PC;
         valid_reg    <= 1'b0;
         instr_reg    <= '0;
         instr_pc_reg <= '0;
      end else begin
         state_reg    <= state_next;
         fpc_reg      <= fpc_next;
         valid_reg    <= valid_next;
         instr_reg    <= instr_next;
         instr_pc_reg <= instr_pc_next;
      end
   end

   assign rom_addr    = fpc_reg;
   assign instr_valid = valid_reg;
   assign instr       = instr_reg;
   assign instr_pc    = instr_pc_reg;

`ifdef PC_FETCH_STATS_EN
   logic [31:0] fetch_count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count_reg <= '0;
      end else if (handshake) begin
         fetch_count_reg <= fetch_count_reg + 32'd1;
      end
   end

   assign fetch_count = fetch_count_reg;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed bench for pc_fetch_unit with a behavioural synchronous ROM.
// ROM contents: words 0..3 = 1234, 5678, 9ABC, DEF0; any other address a holds
// ({1'b1, a} ^ 16'h3C3C). Expected values in the checks are written out by hand.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        jump_en;
   logic [14:0] jump_addr;
   logic [14:0] rom_addr;
   logic [15:0] rom_data = '0;
   logic        instr_valid;
   logic [15:0] instr;
   logic [14:0] instr_pc;
   logic        instr_ready;
`ifdef PC_FETCH_STATS_EN
   logic [31:0] fetch_count;
   logic [31:0] hs_model = '0;
   logic [31:0] count_before;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] rom [0:32767];

   always #5 clk = ~clk;

   pc_fetch_unit #(
      .ADDR_W       (15),
      .DATA_W       (16),
      .RESET_VECTOR (0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .jump_en     (jump_en),
      .jump_addr   (jump_addr),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready)
`ifdef PC_FETCH_STATS_EN
      ,
      .fetch_count (fetch_count)
`endif
   );

   // synchronous ROM, one cycle read latency
   always @(posedge clk) rom_data <= rom[rom_addr];

`ifdef PC_FETCH_STATS_EN
   // handshake counter observed on the interface
   always @(posedge clk) begin
      if (reset) hs_model <= '0;
      else if (instr_valid && instr_ready) hs_model <= hs_model + 32'd1;
   end
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_instr(input string tag, input logic [14:0] pc, input logic [15:0] data);
      check({tag, ".valid"}, 32'(instr_valid), 32'd1);
      check({tag, ".pc"},    32'(instr_pc),    32'(pc));
      check({tag, ".instr"}, 32'(instr),       32'(data));
   endtask

   task automatic expect_idle(input string tag);
      check({tag, ".valid"}, 32'(instr_valid), 32'd0);
   endtask

   initial begin
      logic [15:0] mid_data [0:3];
      mid_data[0] = 16'h9ABC;
      mid_data[1] = 16'hDEF0;
      mid_data[2] = 16'hBC38;
      mid_data[3] = 16'hBC39;

      for (int a = 0; a < 32768; a++) rom[a] = {1'b1, 15'(a)} ^ 16'h3C3C;
      rom[0] = 16'h1234;
      rom[1] = 16'h5678;
      rom[2] = 16'h9ABC;
      rom[3] = 16'hDEF0;

      reset       = 1'b1;
      jump_en     = 1'b0;
      jump_addr   = '0;
      instr_ready = 1'b1;
      repeat (3) tick();

      // reset state
      check("rst.valid",    32'(instr_valid), 32'd0);
      check("rst.instr",    32'(instr),       32'd0);
      check("rst.pc",       32'(instr_pc),    32'd0);
      check("rst.rom_addr", 32'(rom_addr),    32'd0);

      // 1: start-up latency and streaming
      reset = 1'b0;
      tick(); expect_idle("t1.e1");
      tick(); expect_instr("t1.pc0", 15'd0, 16'h1234);
      tick(); expect_idle("t1.gap0");
      instr_ready = 1'b0;
      tick(); expect_instr("t1.pc1", 15'd1, 16'h5678);

      // 2: back-pressure holds everything stable
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_instr("t2.hold", 15'd1, 16'h5678);
         check("t2.rom_addr", 32'(rom_addr), 32'd2);
      end
      instr_ready = 1'b1;
      tick(); expect_idle("t2.gap1");
      tick(); expect_instr("t2.pc2", 15'd2, 16'h9ABC);
      tick(); expect_idle("t2.gap2");
      tick(); expect_instr("t2.pc3", 15'd3, 16'hDEF0);

      // 3: jump while in S_RESP drops the stale read
      tick(); expect_idle("t3.resp");
      jump_en   = 1'b1;
      jump_addr = 15'h0100;
      tick();
      expect_idle("t3.jedge");
      check("t3.rom_addr", 32'(rom_addr), 32'h0100);
      jump_en = 1'b0;
      tick(); expect_idle("t3.e1");
      tick(); expect_instr("t3.tgt", 15'h0100, 16'hBD3C);

      // 4: jump to top of ROM, wrap to 0
      jump_en   = 1'b1;
      jump_addr = 15'h7FFF;
      tick(); expect_idle("t4.jedge");
      jump_en = 1'b0;
      tick(); expect_idle("t4.e1");
      tick();
      expect_instr("t4.top", 15'h7FFF, 16'hC3C3);
      check("t4.wrap_addr", 32'(rom_addr), 32'd0);
      tick(); expect_idle("t4.gap0");
      tick(); expect_instr("t4.pc0", 15'd0, 16'h1234);
      tick(); expect_idle("t4.gap1");
      tick(); expect_instr("t4.pc1", 15'd1, 16'h5678);
      for (int p = 2; p <= 5; p++) begin
         tick(); expect_idle("t4.gap");
         tick(); expect_instr("t4.stream", 15'(p), mid_data[p-2]);
      end

      // 5: jump coincident with handshake at pc=5
`ifdef PC_FETCH_STATS_EN
      count_before = fetch_count;
      check("t5.count_pre", fetch_count, hs_model);
`endif
      jump_en   = 1'b1;
      jump_addr = 15'h0200;
      tick(); expect_idle("t5.jedge");
      jump_en = 1'b0;
      tick(); expect_idle("t5.e1");
      tick(); expect_instr("t5.tgt", 15'h0200, 16'hBE3C);
`ifdef PC_FETCH_STATS_EN
      check("t5.count_inc", fetch_count, count_before + 32'd1);
`endif

      // 6: reset while holding at pc=7, with a competing jump
      instr_ready = 1'b0;
      jump_en     = 1'b1;
      jump_addr   = 15'h0007;
      tick(); expect_idle("t6.jedge");
      jump_en = 1'b0;
      tick(); expect_idle("t6.e1");
      tick(); expect_instr("t6.pc7", 15'd7, 16'hBC3B);
      tick(); expect_instr("t6.hold", 15'd7, 16'hBC3B);
      reset     = 1'b1;
      jump_en   = 1'b1;
      jump_addr = 15'h0300;
      tick();
      check("t6.rst_valid", 32'(instr_valid), 32'd0);
      check("t6.rst_instr", 32'(instr),       32'd0);
      check("t6.rst_pc",    32'(instr_pc),    32'd0);
      check("t6.rst_addr",  32'(rom_addr),    32'd0);
`ifdef PC_FETCH_STATS_EN
      check("t6.rst_count", fetch_count, 32'd0);
`endif
      reset       = 1'b0;
      jump_en     = 1'b0;
      instr_ready = 1'b1;
      tick(); expect_idle("t6.e1r");
      tick(); expect_instr("t6.restart", 15'd0, 16'h1234);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
